// File: rtl/aurora_ingress_gate_if.sv
// NCHAN parallel AXI-stream lanes sharing one bundle; lane i data at [DWIDTH*i +: DWIDTH].
// master drives payload/valid/last, slave drives ready.
interface aurora_ingress_gate_if #(
  parameter int NCHAN  = 4,
  parameter int DWIDTH = 32
);
  logic [NCHAN*DWIDTH-1:0] tdata;
  logic [NCHAN-1:0]        tvalid;
  logic [NCHAN-1:0]        tlast;
  logic [NCHAN-1:0]        tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/aurora_ingress_gate.sv
// Per-channel Aurora event gate: whole frames are forwarded or dropped, state changes only between frames.
// Zero-latency data path; optional INGRESS_GATE_PASSCNT_EN builds per-channel forwarded-frame counters.
module aurora_ingress_gate #(
  parameter int NCHAN     = 4,
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       open_i,
  input  logic [NCHAN-1:0]           chan_mask_i,
  aurora_ingress_gate_if.slave       s_axis,
  aurora_ingress_gate_if.master      m_axis,
  output logic [NCHAN-1:0]           pass_o,
  output logic                       busy_o,
  input  logic                       drop_clear_i,
  output logic [NCHAN*CNT_WIDTH-1:0] drop_count_o,
  output logic [NCHAN*CNT_WIDTH-1:0] pass_count_o
);

  typedef enum logic {DISCARD = 1'b0, PASS = 1'b1} state_t;

  state_t                          state_q [NCHAN];
  logic [NCHAN-1:0]                in_frame_q;
  logic [NCHAN-1:0]                in_frame_d;
  logic [NCHAN-1:0]                en;
  logic [NCHAN-1:0]                accept;
  logic [NCHAN-1:0]                eop;
  logic [NCHAN-1:0][CNT_WIDTH-1:0] drop_q;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                    input logic inc, input logic clr);
    if (clr)              return inc ? CNT_WIDTH'(1) : '0;
    if (inc && (c != '1)) return c + CNT_WIDTH'(1);
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < NCHAN; i++) pass_o[i] = (state_q[i] == PASS);
  end

  // aresetn gates tready directly so upstream sees 0 without waiting for a clock edge.
  assign s_axis.tready = (pass_o & m_axis.tready) | (~pass_o & {NCHAN{aresetn}});
  assign m_axis.tvalid = s_axis.tvalid & pass_o;
  assign m_axis.tlast  = s_axis.tlast & pass_o;

  for (genvar g = 0; g < NCHAN; g++) begin : g_data
    assign m_axis.tdata[DWIDTH*g +: DWIDTH] = pass_o[g] ? s_axis.tdata[DWIDTH*g +: DWIDTH] : '0;
  end

  always_comb begin
    en         = open_i ? ~chan_mask_i : '0;
    accept     = s_axis.tvalid & s_axis.tready;
    eop        = accept & s_axis.tlast;
    in_frame_d = (accept & ~s_axis.tlast) | (~accept & in_frame_q);
  end

  assign busy_o = |in_frame_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_frame_q <= '0;
      for (int i = 0; i < NCHAN; i++) state_q[i] <= DISCARD;
    end else begin
      in_frame_q <= in_frame_d;
      for (int i = 0; i < NCHAN; i++) begin
        // Only re-evaluate the gate once the current frame has fully gone by.
        if (!in_frame_d[i]) begin
          case (state_q[i])
            DISCARD: if (en[i])  state_q[i] <= PASS;
            PASS:    if (!en[i]) state_q[i] <= DISCARD;
            default: state_q[i] <= DISCARD;
          endcase
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_q <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++)
        drop_q[i] <= cnt_next(drop_q[i], eop[i] & ~pass_o[i], drop_clear_i);
    end
  end

  assign drop_count_o = drop_q;

`ifdef INGRESS_GATE_PASSCNT_EN
  logic [NCHAN-1:0][CNT_WIDTH-1:0] pass_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pass_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++)
        pass_cnt_q[i] <= cnt_next(pass_cnt_q[i], eop[i] & pass_o[i], drop_clear_i);
    end
  end

  assign pass_count_o = pass_cnt_q;
`else
  assign pass_count_o = '0;
`endif

endmodule

// File: tb/tb_aurora_ingress_gate.sv
// Randomised bench for aurora_ingress_gate: frame-level reference model feeds a scoreboard,
// an independent monitor pops and compares every forwarded beat.
module tb_aurora_ingress_gate;
  localparam int NCHAN     = 4;
  localparam int DWIDTH    = 32;
  localparam int CNT_WIDTH = 4;
  localparam int CMAX      = (1 << CNT_WIDTH) - 1;

  logic                       aclk = 1'b0;
  logic                       aresetn = 1'b0;
  logic                       open_i = 1'b0;
  logic [NCHAN-1:0]           chan_mask_i = '0;
  logic                       drop_clear_i = 1'b0;
  logic [NCHAN-1:0]           pass_o;
  logic                       busy_o;
  logic [NCHAN*CNT_WIDTH-1:0] drop_count_o;
  logic [NCHAN*CNT_WIDTH-1:0] pass_count_o;

  aurora_ingress_gate_if #(.NCHAN(NCHAN), .DWIDTH(DWIDTH)) s_axis ();
  aurora_ingress_gate_if #(.NCHAN(NCHAN), .DWIDTH(DWIDTH)) m_axis ();

  aurora_ingress_gate #(.NCHAN(NCHAN), .DWIDTH(DWIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .open_i(open_i), .chan_mask_i(chan_mask_i),
    .s_axis(s_axis), .m_axis(m_axis), .pass_o(pass_o), .busy_o(busy_o),
    .drop_clear_i(drop_clear_i), .drop_count_o(drop_count_o), .pass_count_o(pass_count_o)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {logic [DWIDTH-1:0] d; logic l;} beat_t;
  beat_t sbq [NCHAN][$];

  int checks = 0;
  int fails  = 0;

  // Reference model: a channel forwards a frame iff the gate was open for new frames when its
  // first beat was taken; between frames the gate follows en with one cycle of lag.
  bit mdl_open    [NCHAN];
  bit mdl_inframe [NCHAN];
  int exp_drop    [NCHAN];
  int exp_pass    [NCHAN];

  // Stimulus generator state
  int          want [NCHAN];
  int          flen [NCHAN];
  int          cur_len [NCHAN];
  int          bidx [NCHAN];
  bit          active [NCHAN];
  bit          vld [NCHAN];
  logic [31:0] hold_d [NCHAN];
  int          start_pct = 60;
  int          valid_pct = 80;
  bit          rand_bp = 1'b0;
  bit          clear_on_last = 1'b0;
  bit          nxt_open = 1'b0;
  bit          nxt_clear = 1'b0;
  logic [NCHAN-1:0] nxt_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat_upd(input int c, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc) return (c < CMAX) ? c + 1 : CMAX;
    return c;
  endfunction

  function automatic bit gen_busy();
    for (int ch = 0; ch < NCHAN; ch++) if (active[ch] || want[ch] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] dcnt(input int ch);
    return drop_count_o[ch*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] pcnt(input int ch);
    return pass_count_o[ch*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  task automatic set_gen(input int ch, input int n, input int len);
    want[ch] = n;
    flen[ch] = len;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCHAN; ch++) begin
      mdl_open[ch] = 0; mdl_inframe[ch] = 0; exp_drop[ch] = 0; exp_pass[ch] = 0;
      want[ch] = 0; active[ch] = 0; vld[ch] = 0; bidx[ch] = 0;
      sbq[ch].delete();
    end
  endtask

  task automatic drive_inputs();
    aresetn     = 1'b1;
    open_i      = nxt_open;
    chan_mask_i = nxt_mask;
    for (int ch = 0; ch < NCHAN; ch++) begin
      if (!active[ch] && want[ch] > 0 && $urandom_range(99) < start_pct) begin
        active[ch]  = 1'b1;
        want[ch]    = want[ch] - 1;
        cur_len[ch] = (flen[ch] > 0) ? flen[ch] : int'($urandom_range(6, 1));
        bidx[ch]    = 0;
        vld[ch]     = 1'b0;
        hold_d[ch]  = $urandom;
      end
      if (active[ch] && !vld[ch]) vld[ch] = ($urandom_range(99) < valid_pct);
      s_axis.tvalid[ch] = vld[ch];
      s_axis.tlast[ch]  = active[ch] && (bidx[ch] == cur_len[ch] - 1);
      s_axis.tdata[ch*DWIDTH +: DWIDTH] = hold_d[ch];
      m_axis.tready[ch] = rand_bp ? ($urandom_range(2) != 0) : 1'b1;
    end
    drop_clear_i = nxt_clear || (clear_on_last && vld[0] && s_axis.tlast[0]);
  endtask

  task automatic evaluate();
    chk("busy_o", busy_o, (mdl_inframe[0] | mdl_inframe[1] | mdl_inframe[2] | mdl_inframe[3]));
    for (int ch = 0; ch < NCHAN; ch++) begin
      bit en, rdy, acc, lst;
      en  = open_i && !chan_mask_i[ch];
      rdy = mdl_open[ch] ? m_axis.tready[ch] : 1'b1;
      chk($sformatf("pass_o ch%0d", ch), pass_o[ch], mdl_open[ch]);
      chk($sformatf("s_tready ch%0d", ch), s_axis.tready[ch], rdy);
      chk($sformatf("m_tvalid ch%0d", ch), m_axis.tvalid[ch], mdl_open[ch] & s_axis.tvalid[ch]);
      chk($sformatf("drop_count ch%0d", ch), dcnt(ch), exp_drop[ch]);
`ifdef INGRESS_GATE_PASSCNT_EN
      chk($sformatf("pass_count ch%0d", ch), pcnt(ch), exp_pass[ch]);
`else
      chk($sformatf("pass_count ch%0d", ch), pcnt(ch), 0);
`endif
      acc = s_axis.tvalid[ch] && rdy;
      lst = s_axis.tlast[ch];
      exp_drop[ch] = sat_upd(exp_drop[ch], acc && lst && !mdl_open[ch], drop_clear_i);
      exp_pass[ch] = sat_upd(exp_pass[ch], acc && lst && mdl_open[ch], drop_clear_i);
      if (acc) begin
        if (mdl_open[ch]) sbq[ch].push_back({hold_d[ch], lst});
        mdl_inframe[ch] = !lst;
        vld[ch] = 1'b0;
        if (lst) active[ch] = 1'b0;
        else begin
          bidx[ch]   = bidx[ch] + 1;
          hold_d[ch] = $urandom;
        end
      end
      if (!mdl_inframe[ch]) mdl_open[ch] = en;
    end
  endtask

  task automatic step();
    @(negedge aclk);
    drive_inputs();
    #2;
    evaluate();
  endtask

  task automatic run_idle(input int limit, input string tag);
    int n = 0;
    while (gen_busy() && n < limit) begin
      step();
      n++;
    end
    chk({tag, " completes"}, gen_busy(), 0);
    repeat (3) step();
  endtask

  task automatic wait_beat(input int ch, input int b, input string tag);
    int n = 0;
    while (!(active[ch] && bidx[ch] == b) && n < 200) begin
      step();
      n++;
    end
    chk({tag, " reached"}, (active[ch] && bidx[ch] == b), 1);
  endtask

  // Scoreboard monitor, sampling after the driver's model update and before the next rising edge.
  initial begin
    forever begin
      @(negedge aclk);
      #3;
      for (int ch = 0; ch < NCHAN; ch++) begin
        if (m_axis.tvalid[ch] && m_axis.tready[ch]) begin
          if (sbq[ch].size() == 0) begin
            checks++;
            fails++;
            $display("FAIL sb_extra ch%0d: got beat 0x%0h, expected no beat", ch,
                     m_axis.tdata[ch*DWIDTH +: DWIDTH]);
          end else begin
            beat_t e;
            e = sbq[ch].pop_front();
            chk($sformatf("sb_tdata ch%0d", ch), m_axis.tdata[ch*DWIDTH +: DWIDTH], e.d);
            chk($sformatf("sb_tlast ch%0d", ch), m_axis.tlast[ch], e.l);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, " s_tready"}, s_axis.tready, 0);
    chk({tag, " m_tvalid"}, m_axis.tvalid, 0);
    chk({tag, " m_tlast"}, m_axis.tlast, 0);
    chk({tag, " m_tdata"}, m_axis.tdata[63:0], 0);
    chk({tag, " pass_o"}, pass_o, 0);
    chk({tag, " busy_o"}, busy_o, 0);
    chk({tag, " drop_count"}, drop_count_o, 0);
    chk({tag, " pass_count"}, pass_count_o, 0);
  endtask

  initial begin
    model_reset();
    s_axis.tvalid = '1;
    s_axis.tlast  = '1;
    s_axis.tdata  = {4{32'hA5A5_5A5A}};
    m_axis.tready = '1;
    open_i        = 1'b1;
    #2;
    check_reset_outputs("reset");

    // Closed gate drops whole frames.
    nxt_open = 1'b0;
    set_gen(0, 3, 4);
    run_idle(300, "closed");
    chk("closed drop ch0", dcnt(0), 3);

    // Open gate forwards under back-pressure.
    nxt_open = 1'b1;
    rand_bp  = 1'b1;
    repeat (2) step();
    set_gen(1, 1, 8);
    run_idle(300, "open_bp");
    chk("open_bp drop ch1", dcnt(1), 0);
`ifdef INGRESS_GATE_PASSCNT_EN
    chk("open_bp pass ch1", pcnt(1), 1);
`endif
    chk("open_bp sb ch1 drained", sbq[1].size(), 0);

    // Gate opens during the second beat of a 5-beat frame.
    rand_bp  = 1'b0;
    nxt_open = 1'b0;
    repeat (2) step();
    set_gen(2, 1, 5);
    wait_beat(2, 1, "open_mid");
    nxt_open = 1'b1;
    run_idle(300, "open_mid");
    chk("open_mid drop ch2", dcnt(2), 1);
    set_gen(2, 1, 5);
    run_idle(300, "open_mid next");
    chk("open_mid next drop ch2", dcnt(2), 1);
    chk("open_mid pass_o ch2", pass_o[2], 1);

    // Gate closes at beat 3 of a 6-beat frame in PASS.
    set_gen(3, 1, 6);
    wait_beat(3, 2, "close_mid");
    nxt_open = 1'b0;
    run_idle(300, "close_mid");
    chk("close_mid drop ch3", dcnt(3), 0);
    chk("close_mid pass_o ch3", pass_o[3], 0);
    set_gen(3, 1, 6);
    run_idle(300, "close_mid next");
    chk("close_mid next drop ch3", dcnt(3), 1);

    // Saturation, then clear colliding with a dropped tlast.
    valid_pct = 100;
    set_gen(0, 20, 1);
    run_idle(600, "saturate");
    chk("saturate drop ch0", dcnt(0), CMAX);
    clear_on_last = 1'b1;
    set_gen(0, 1, 1);
    run_idle(100, "clear_collide");
    clear_on_last = 1'b0;
    chk("clear_collide drop ch0", dcnt(0), 1);
    chk("clear_collide drop ch2", dcnt(2), 0);

    // Masked channel drops while its neighbour forwards.
    valid_pct = 80;
    rand_bp   = 1'b1;
    nxt_open  = 1'b1;
    nxt_mask  = 4'b0001;
    repeat (2) step();
    set_gen(0, 2, 3);
    set_gen(1, 2, 3);
    run_idle(400, "mask");
    chk("mask drop ch0", dcnt(0), 3);
    chk("mask drop ch1", dcnt(1), 0);
    chk("mask pass_o ch0", pass_o[0], 0);
    chk("mask pass_o ch1", pass_o[1], 1);

    // Asynchronous reset in the middle of a forwarded frame.
    rand_bp   = 1'b0;
    valid_pct = 100;
    nxt_mask  = '0;
    set_gen(1, 1, 8);
    wait_beat(1, 3, "rst_mid");
    @(negedge aclk);
    #1;
    chk("rst_mid m_tvalid before", m_axis.tvalid[1], 1);
    chk("rst_mid busy before", busy_o, 1);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    s_axis.tvalid = '0;
    repeat (2) @(negedge aclk);

    // Randomised traffic with toggling gate, masks and clears.
    valid_pct = 80;
    rand_bp   = 1'b1;
    start_pct = 50;
    for (int ch = 0; ch < NCHAN; ch++) set_gen(ch, 100000, 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19) == 0) nxt_open = ~nxt_open;
      if ($urandom_range(39) == 0) nxt_mask = NCHAN'($urandom);
      nxt_clear = ($urandom_range(49) == 0);
      step();
    end
    nxt_clear = 1'b0;
    for (int ch = 0; ch < NCHAN; ch++) want[ch] = 0;
    run_idle(500, "random drain");
    for (int ch = 0; ch < NCHAN; ch++)
      chk($sformatf("random sb ch%0d drained", ch), sbq[ch].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
